uart_frame_to_fifo: RTL and testbench
=====================================

// Module: uart_frame_to_fifo
// PURPOSE
//   Parametrised successor of the serial-to-FIFO bridge. Receives UART bytes
//   and writes each byte to the downstream FIFO under the fifo_busy/fifo_we
//   handshake. Runs a serial CRC-8 over every byte and groups bytes into
//   FRAME_LEN-byte frames. Adds a FIFO-wait timeout plus sticky overrun,
//   framing and timeout flags. Sits between the board rx pin and the shared
//   byte FIFO.
// PARAMETERS
//   CLKS_PER_BIT  5208   clk cycles per UART bit (50 MHz / 9600 baud)
//   DATA_W        8      UART data bits per character (5..8)
//   CRC_POLY      8'h07  CRC-8 polynomial, implicit x^8
//   CRC_INIT      8'h00  CRC register value at reset and at each frame start
//   FRAME_LEN     16     bytes per frame (>=2)
//   FIFO_TIMEOUT  1024   max cycles spent waiting on fifo_busy before the byte is dropped
// PORTS
//   clk            in   1       system clock
//   reset          in   1       synchronous, active-high
//   enable         in   1       1 = FSM advances; 0 = FSM frozen
//   clear_err      in   1       1-cycle pulse clears the sticky error flags
//   rx             in   1       UART serial in
//   tx             out  1       loopback: tx = rx (combinational)
//   fifo_busy      in   1       FIFO cannot accept a write this cycle
//   fifo_we        out  1       1-cycle write strobe
//   fifo_data_out  out  DATA_W  byte presented to the FIFO, stable while fifo_we=1
//   crc            out  8       running CRC, or final CRC once crc_valid=1
//   crc_valid      out  1       high from DONE until the next frame's first byte
//   crc_err        out  1       CRC mismatch (CRC_CHECK_EN only)
//   frame_done     out  1       1-cycle pulse at end of frame
//   byte_count     out  $clog2(FRAME_LEN)  bytes accepted in the current frame
//   overrun        out  1       sticky: a byte arrived while the FSM was not IDLE
//   rx_err         out  1       sticky: stop bit sampled low
//   timeout_err    out  1       sticky: fifo_busy held for FIFO_TIMEOUT cycles
//   state          out  3       FSM state, debug only
// BEHAVIOUR
//   - Reset: every output 0 except tx; crc=CRC_INIT; FSM=IDLE.
//   - The rx core always runs. It emits rx_valid (1 cycle), rx_data and stop_bad.
//   - IDLE(0): on rx_valid && enable:
//       stop_bad -> set rx_err, drop byte, stay IDLE;
//       else latch fifo_data_out, go WAIT(1). If byte_count==0, crc<=CRC_INIT
//       and crc_valid<=0 in the same cycle.
//   - A byte arriving while enable=0 is dropped silently (no flag).
//   - rx_valid in any state other than IDLE: set overrun, drop the new byte;
//     the byte in flight is unaffected.
//   - WAIT(1): fifo_busy=0 -> fifo_we=1 next cycle, go WRITE(2). Otherwise the
//     wait counter increments. At FIFO_TIMEOUT: set timeout_err, drop the byte
//     (no CRC update, no count), return to IDLE.
//   - WRITE(2): fifo_we=0, bit index = DATA_W-1, go CRC(3).
//   - Latency: rx_valid to fifo_we is 2 cycles when fifo_busy=0.
//   - CRC(3): one bit per cycle, MSB first:
//       fb = crc[7]^d[i];  crc <= {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0)
//     After DATA_W cycles, byte_count++. If byte_count reaches FRAME_LEN, go
//     DONE(4); else go IDLE.
//   - DONE(4): frame_done=1 for one cycle, crc_valid=1, byte_count=0, go IDLE.
//   - enable=0 freezes the FSM, counters and crc. fifo_we is forced 0 while frozen.
//   - clear_err clears the sticky flags. If clear_err coincides with a new
//     error, the set wins.
//   - Reset mid-frame: frame abandoned, count 0, no frame_done.
// CONFIGURATION
//   CRC_CHECK_EN defined:
//     - The last byte of each frame is a CRC trailer. It is written to the FIFO
//       but excluded from the CRC.
//     - In DONE, crc_err = (trailer != crc). crc_err holds until the next
//       frame's first byte.
//   CRC_CHECK_EN undefined: all FRAME_LEN bytes enter the CRC; crc_err tied 0.
// STRUCTURE
//   - Package uart_fifo_pkg: state enum (IDLE/WAIT/WRITE/CRC/DONE), default
//     CRC_POLY/CRC_INIT localparams, crc8_step() function.
//   - Sub-module uart_rx_core (CLKS_PER_BIT, DATA_W): mid-bit sampling with a
//     2-FF rx synchroniser. Outputs rx_valid, rx_data, stop_bad.
// TESTING
//   - FRAME_LEN=9, CRC_CHECK_EN undefined, send "123456789", fifo_busy=0
//       -> 9 fifo_we pulses in order, frame_done once, crc=8'hF4, crc_valid=1.
//   - CRC_CHECK_EN defined, FRAME_LEN=10, "123456789" then 8'hF4 -> crc_err=0;
//     same frame with trailer 8'hF5 -> crc_err=1. All 10 bytes written in both cases.
//   - fifo_busy held 1 for 1023 cycles then released -> byte written, no error;
//     held for 1024 cycles -> timeout_err=1, no write, byte_count unchanged.
//   - Second byte injected at rx_valid while the FSM is in CRC -> overrun=1;
//     first byte written; second byte absent from the FIFO.
//   - Byte with stop bit forced 0 -> rx_err=1, no fifo_we. A clear_err pulse
//     returns rx_err to 0.
//   - reset asserted after byte 4 of a frame -> all outputs 0, crc=CRC_INIT;
//     the next 9 bytes form a full frame with correct CRC.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared types and helpers for the UART-to-FIFO bridge: FSM state encodings,
// default CRC-8 constants and a single-bit CRC-8 update step.
package uart_fifo_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWait  = 3'd1,
        StWrite = 3'd2,
        StCrc   = 3'd3,
        StDone  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        RxIdle  = 3'd0,
        RxStart = 3'd1,
        RxData  = 3'd2,
        RxStop  = 3'd3,
        RxBreak = 3'd4
    } rx_state_e;

    localparam logic [7:0] CRC_POLY_DEF = 8'h07;
    localparam logic [7:0] CRC_INIT_DEF = 8'h00;

    // MSB-first serial CRC-8, implicit x^8 term.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic d,
                                             input logic [7:0] poly);
        logic fb;
        fb = crc[7] ^ d;
        return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling, LSB first, one stop bit.
// Emits a 1-cycle rx_valid with the data and a stop_bad flag.
module uart_rx_core import uart_fifo_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx,
    output logic              o_rx_valid,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_stop_bad
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    rx_state_e         r_state;
    logic [1:0]        r_sync;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic              w_rx;

    assign w_rx = r_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= RxIdle;
            r_sync     <= 2'b11;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            o_rx_valid <= 1'b0;
            o_rx_data  <= '0;
            o_stop_bad <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_rx};
            o_rx_valid <= 1'b0;
            case (r_state)
                RxIdle: begin
                    r_clk_cnt <= '0;
                    if (!w_rx) r_state <= RxStart;
                end
                RxStart: begin
                    if (r_clk_cnt == HALF_CNT) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        // A start bit that has gone high again by mid-bit was a glitch.
                        r_state   <= w_rx ? RxIdle : RxData;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (r_clk_cnt == FULL_CNT) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx, r_shift[DATA_W-1:1]};
                        if (r_bit_idx == LAST_BIT) r_state <= RxStop;
                        else r_bit_idx <= r_bit_idx + 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (r_clk_cnt == FULL_CNT) begin
                        r_clk_cnt  <= '0;
                        o_rx_valid <= 1'b1;
                        o_rx_data  <= r_shift;
                        o_stop_bad <= ~w_rx;
                        r_state    <= w_rx ? RxIdle : RxBreak;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RxBreak: begin
                    // Wait for the line to return high so a low stop bit is not a new start.
                    if (w_rx) r_state <= RxIdle;
                end
                default: r_state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_to_fifo.sv
// UART-to-FIFO bridge with CRC-8 framing, FIFO-wait timeout and sticky error flags.
// Define CRC_CHECK_EN to treat the last byte of each frame as a CRC trailer.
module uart_frame_to_fifo import uart_fifo_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_W       = 8,
    parameter logic [7:0]  CRC_POLY     = CRC_POLY_DEF,
    parameter logic [7:0]  CRC_INIT     = CRC_INIT_DEF,
    parameter int unsigned FRAME_LEN    = 16,
    parameter int unsigned FIFO_TIMEOUT = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_clear_err,
    input  logic                         i_rx,
    output logic                         o_tx,
    input  logic                         i_fifo_busy,
    output logic                         o_fifo_we,
    output logic [DATA_W-1:0]            o_fifo_data_out,
    output logic [7:0]                   o_crc,
    output logic                         o_crc_valid,
    output logic                         o_crc_err,
    output logic                         o_frame_done,
    output logic [$clog2(FRAME_LEN)-1:0] o_byte_count,
    output logic                         o_overrun,
    output logic                         o_rx_err,
    output logic                         o_timeout_err,
    output logic [2:0]                   o_state
);
    localparam int unsigned CNT_W  = $clog2(FRAME_LEN);
    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned WAIT_W = (FIFO_TIMEOUT > 2) ? $clog2(FIFO_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(FIFO_TIMEOUT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

    logic              w_rx_valid;
    logic [DATA_W-1:0] w_rx_data;
    logic              w_stop_bad;
    logic              w_trailer;

    state_e            r_state;
    logic [DATA_W-1:0] r_data;
    logic [7:0]        r_crc;
    logic              r_crc_valid;
    logic              r_fifo_we;
    logic              r_frame_done;
    logic [CNT_W-1:0]  r_byte_count;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [BIT_W-1:0]  r_bit_idx;
    logic              r_overrun;
    logic              r_rx_err;
    logic              r_timeout_err;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_W       (DATA_W)
    ) u_rx_core (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rx       (i_rx),
        .o_rx_valid (w_rx_valid),
        .o_rx_data  (w_rx_data),
        .o_stop_bad (w_stop_bad)
    );

`ifdef CRC_CHECK_EN
    logic       r_crc_err;
    logic [7:0] w_data8;

    assign w_trailer = (r_byte_count == LAST_CNT);
    assign o_crc_err = r_crc_err;

    always_comb begin
        w_data8              = '0;
        w_data8[DATA_W-1:0]  = r_data;
    end
`else
    assign w_trailer = 1'b0;
    assign o_crc_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_data        <= '0;
            r_crc         <= CRC_INIT;
            r_crc_valid   <= 1'b0;
            r_fifo_we     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_byte_count  <= '0;
            r_wait_cnt    <= '0;
            r_bit_idx     <= '0;
            r_overrun     <= 1'b0;
            r_rx_err      <= 1'b0;
            r_timeout_err <= 1'b0;
`ifdef CRC_CHECK_EN
            r_crc_err     <= 1'b0;
`endif
        end else begin
            // Clear first so any error raised later in this cycle wins.
            if (i_clear_err) begin
                r_overrun     <= 1'b0;
                r_rx_err      <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            r_frame_done <= 1'b0;
            if (w_rx_valid && r_state != StIdle) r_overrun <= 1'b1;

            if (i_enable) begin
                case (r_state)
                    StIdle: begin
                        if (w_rx_valid) begin
                            if (w_stop_bad) begin
                                r_rx_err <= 1'b1;
                            end else begin
                                r_data     <= w_rx_data;
                                r_wait_cnt <= '0;
                                r_state    <= StWait;
                                if (r_byte_count == '0) begin
                                    r_crc       <= CRC_INIT;
                                    r_crc_valid <= 1'b0;
`ifdef CRC_CHECK_EN
                                    r_crc_err   <= 1'b0;
`endif
                                end
                            end
                        end
                    end
                    StWait: begin
                        if (!i_fifo_busy) begin
                            r_fifo_we <= 1'b1;
                            r_state   <= StWrite;
                        end else if (r_wait_cnt == WAIT_MAX) begin
                            r_timeout_err <= 1'b1;
                            r_state       <= StIdle;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                    StWrite: begin
                        r_fifo_we <= 1'b0;
                        r_bit_idx <= LAST_BIT;
                        r_state   <= StCrc;
                    end
                    StCrc: begin
                        if (!w_trailer) r_crc <= crc8_step(r_crc, r_data[r_bit_idx], CRC_POLY);
                        if (r_bit_idx == '0) begin
                            if (r_byte_count == LAST_CNT) begin
                                r_byte_count <= '0;
                                r_state      <= StDone;
                            end else begin
                                r_byte_count <= r_byte_count + 1'b1;
                                r_state      <= StIdle;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx - 1'b1;
                        end
                    end
                    StDone: begin
                        r_frame_done <= 1'b1;
                        r_crc_valid  <= 1'b1;
`ifdef CRC_CHECK_EN
                        r_crc_err    <= (w_data8 != r_crc);
`endif
                        r_state      <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_tx            = i_rx;
    assign o_fifo_we       = r_fifo_we & i_enable;
    assign o_fifo_data_out = r_data;
    assign o_crc           = r_crc;
    assign o_crc_valid     = r_crc_valid;
    assign o_frame_done    = r_frame_done;
    assign o_byte_count    = r_byte_count;
    assign o_overrun       = r_overrun;
    assign o_rx_err        = r_rx_err;
    assign o_timeout_err   = r_timeout_err;
    assign o_state         = r_state;

endmodule

// File: tb/tb_uart_frame_to_fifo.sv
// Self-checking bench for uart_frame_to_fifo; expected FIFO bytes go through a scoreboard queue.
// Also exercises the CRC trailer check when CRC_CHECK_EN is defined.
module tb_uart_frame_to_fifo;
    localparam int unsigned CPB    = 8;
    localparam int unsigned DATA_W = 8;
`ifdef CRC_CHECK_EN
    localparam int unsigned FLEN   = 10;
`else
    localparam int unsigned FLEN   = 9;
`endif
    localparam int unsigned TMO    = 1024;
    localparam int unsigned CNT_W  = $clog2(FLEN);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic              clear_err = 1'b0;
    logic              rx = 1'b1;
    logic              fifo_busy = 1'b0;
    logic              tx;
    logic              fifo_we;
    logic [DATA_W-1:0] fifo_data;
    logic [7:0]        crc;
    logic              crc_valid;
    logic              crc_err;
    logic              frame_done;
    logic [CNT_W-1:0]  byte_count;
    logic              overrun;
    logic              rx_err;
    logic              timeout_err;
    logic [2:0]        state;

    int                n_cmp = 0;
    int                n_err = 0;
    int                n_frames = 0;
    logic [7:0]        exp_q[$];
    logic [7:0]        got_q[$];

    uart_frame_to_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DATA_W),
        .CRC_POLY     (8'h07),
        .CRC_INIT     (8'h00),
        .FRAME_LEN    (FLEN),
        .FIFO_TIMEOUT (TMO)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_enable        (enable),
        .i_clear_err     (clear_err),
        .i_rx            (rx),
        .o_tx            (tx),
        .i_fifo_busy     (fifo_busy),
        .o_fifo_we       (fifo_we),
        .o_fifo_data_out (fifo_data),
        .o_crc           (crc),
        .o_crc_valid     (crc_valid),
        .o_crc_err       (crc_err),
        .o_frame_done    (frame_done),
        .o_byte_count    (byte_count),
        .o_overrun       (overrun),
        .o_rx_err        (rx_err),
        .o_timeout_err   (timeout_err),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    // Capture every FIFO write and frame_done pulse away from the active edge.
    always @(negedge clk) begin
        if (fifo_we) got_q.push_back(fifo_data);
        if (frame_done) n_frames++;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.delete();
        got_q.delete();
        n_frames = 0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({fifo_we, crc_valid, crc_err, frame_done, overrun, rx_err, timeout_err} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {fifo_we, crc_valid, crc_err, frame_done, overrun, rx_err, timeout_err});
        end
        n_cmp++;
        if (crc !== 8'h00) begin
            n_err++;
            $display("FAIL reset_crc: got %h want 00", crc);
        end
        n_cmp++;
        if (byte_count !== '0 || state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_count_state: got %0d/%0d want 0/0", byte_count, state);
        end
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL tx_loop_hi: got %b want 1", tx);
        end
        rx = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL tx_loop_lo: got %b want 0", tx);
        end
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] trailer);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(8'h31 + 8'(i));
            send_byte(8'h31 + 8'(i), 1'b1);
        end
`ifdef CRC_CHECK_EN
        exp_q.push_back(trailer);
        send_byte(trailer, 1'b1);
`endif
        repeat (40) @(negedge clk);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL frame_writes: got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g;
            logic [7:0] e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL frame_byte: got %h want %h", g, e);
            end
        end
        n_cmp++;
        if (n_frames != 1) begin
            n_err++;
            $display("FAIL frame_done_count: got %0d want 1", n_frames);
        end
        n_frames = 0;
        n_cmp++;
        if (crc !== 8'hF4 || crc_valid !== 1'b1) begin
            n_err++;
            $display("FAIL frame_crc: got %h/%b want f4/1", crc, crc_valid);
        end
        n_cmp++;
        if (byte_count !== '0) begin
            n_err++;
            $display("FAIL frame_count: got %0d want 0", byte_count);
        end
`ifdef CRC_CHECK_EN
        n_cmp++;
        if (crc_err !== (trailer != 8'hF4)) begin
            n_err++;
            $display("FAIL crc_err: got %b want %b", crc_err, trailer != 8'hF4);
        end
`endif
    endtask

    task automatic test_frames();
        do_reset();
        test_frame(8'hF4);
`ifdef CRC_CHECK_EN
        test_frame(8'hF5);
`endif
    endtask

    task automatic timeout_case(input int hold, input logic expect_write);
        int k;
        do_reset();
        fifo_busy = 1'b1;
        if (expect_write) exp_q.push_back(8'h41);
        fork
            send_byte(8'h41, 1'b1);
            begin
                for (k = 0; k < 2000 && state !== 3'd1; k++) @(negedge clk);
                if (k == 2000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL timeout_wait_state: got %0d want 1", state);
                end
                repeat (hold) @(negedge clk);
                fifo_busy = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL timeout_writes_%0d: got %0d want %0d", hold, got_q.size(),
                     exp_q.size());
        end else if (expect_write) begin
            n_cmp++;
            if (got_q[0] !== exp_q[0]) begin
                n_err++;
                $display("FAIL timeout_byte: got %h want %h", got_q[0], exp_q[0]);
            end
        end
        n_cmp++;
        if (timeout_err !== !expect_write) begin
            n_err++;
            $display("FAIL timeout_flag_%0d: got %b want %b", hold, timeout_err, !expect_write);
        end
        n_cmp++;
        if (byte_count !== CNT_W'(expect_write ? 1 : 0)) begin
            n_err++;
            $display("FAIL timeout_count_%0d: got %0d want %0d", hold, byte_count,
                     expect_write ? 1 : 0);
        end
    endtask

    task automatic test_timeout();
        timeout_case(TMO - 1, 1'b1);
        timeout_case(TMO, 1'b0);
    endtask

    task automatic test_overrun();
        int k;
        do_reset();
        exp_q.push_back(8'h31);
        fork
            send_byte(8'h31, 1'b1);
            begin
                for (k = 0; k < 2000 && !fifo_we; k++) @(negedge clk);
                if (k == 2000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL overrun_first_we: got 0 want 1");
                end
                @(negedge clk);
                enable = 1'b0;
            end
        join
        n_cmp++;
        if (state !== 3'd3) begin
            n_err++;
            $display("FAIL frozen_state: got %0d want 3", state);
        end
        send_byte(8'h32, 1'b1);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_flag: got %b want 1", overrun);
        end
        enable = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== 8'h31) begin
            n_err++;
            $display("FAIL overrun_fifo: got %0d bytes want 1 byte 31", got_q.size());
        end
        n_cmp++;
        if (byte_count !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL overrun_count: got %0d want 1", byte_count);
        end
    endtask

    task automatic test_rx_err();
        do_reset();
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rx_err !== 1'b1 || got_q.size() != 0) begin
            n_err++;
            $display("FAIL rx_err_set: got %b/%0d writes want 1/0", rx_err, got_q.size());
        end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rx_err !== 1'b0) begin
            n_err++;
            $display("FAIL rx_err_clear: got %b want 0", rx_err);
        end
    endtask

    task automatic test_disabled();
        do_reset();
        enable = 1'b0;
        send_byte(8'h5A, 1'b1);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 0 || {overrun, rx_err, timeout_err} !== 3'b0 || byte_count !== '0)
        begin
            n_err++;
            $display("FAIL disabled_drop: got %0d writes flags %b want 0 writes flags 000",
                     got_q.size(), {overrun, rx_err, timeout_err});
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h61 + 8'(i), 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (byte_count !== CNT_W'(4)) begin
            n_err++;
            $display("FAIL mid_count: got %0d want 4", byte_count);
        end
        do_reset();
        n_cmp++;
        if (crc !== 8'h00 || byte_count !== '0 || crc_valid !== 1'b0 || state !== 3'd0) begin
            n_err++;
            $display("FAIL mid_reset: got crc %h cnt %0d valid %b st %0d want 00 0 0 0",
                     crc, byte_count, crc_valid, state);
        end
        test_frame(8'hF4);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_timeout();
        test_overrun();
        test_rx_err();
        test_disabled();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
